// File: rtl/ge_select_seq.sv
// ge_select_seq: constant-time fixed-base table selector for Ed25519
// (the ref10 ge_select operation).
//
// Every call reads all 8 ge_precomp entries of one table row, in the order
// 0..7. Entry k holds multiple k+1. Each entry is mask-merged into an
// accumulator that starts at the identity (1, 1, 0). The result is then
// conditionally negated: yplusx and yminusx are swapped, and xy2d is negated
// limb by limb. The access pattern and the latency do not depend on the digit.
//
// Parameters:
//   TBL_RD_LAT  table read latency, 1 or 2 cycles
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           request pulse, accepted only in IDLE
//   b               signed radix-16 digit, latched on accept
//   busy            high whenever the FSM is not in IDLE
//   done            one-cycle pulse; t_* are valid from this cycle on
//   tbl_rd_en       table read strobe
//   tbl_addr        entry index k (holds multiple k+1)
//   tbl_yplusx/yminusx/xy2d  entry data, 10 x 32-bit limbs, limb0 at [31:0]
//   t_yplusx/yminusx/xy2d    selected point, registered
//   b_err           (only with GE_SELECT_RANGE_CHK_EN) digit outside [-8,8]
//
// Optional feature macro: GE_SELECT_RANGE_CHK_EN
module ge_select_seq #(
  parameter int TBL_RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   b,
  output logic         busy,
  output logic         done,
  output logic         tbl_rd_en,
  output logic [2:0]   tbl_addr,
  input  logic [319:0] tbl_yplusx,
  input  logic [319:0] tbl_yminusx,
  input  logic [319:0] tbl_xy2d,
  output logic [319:0] t_yplusx,
  output logic [319:0] t_yminusx,
  output logic [319:0] t_xy2d
`ifdef GE_SELECT_RANGE_CHK_EN
  ,
  output logic         b_err
`endif
);

  localparam int LAST = TBL_RD_LAT - 1;
  localparam logic [319:0] FE_ONE = 320'd1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, NEG, DONE} state_t;

  state_t              state;
  logic [1:0]          drn;
  logic                bneg;
  logic [7:0]          babs;
  logic [319:0]        acc_yplusx;
  logic [319:0]        acc_yminusx;
  logic [319:0]        acc_xy2d;
  logic                vld_p [TBL_RD_LAT];
  logic [2:0]          idx_p [TBL_RD_LAT];
  logic signed [7:0]   b_s;
  logic                accept;
  logic                hit;

  // Per-bit merge: sel=1 takes a, sel=0 keeps keep. No data-dependent enable.
  function automatic logic [319:0] mask_sel(input logic [319:0] a,
                                            input logic [319:0] keep,
                                            input logic         sel);
    logic [319:0] m;
    m = {320{sel}};
    return (a & m) | (keep & ~m);
  endfunction

  // Per-limb 32-bit two's-complement negation, with no carry between limbs.
  function automatic logic [319:0] neg_limbs(input logic [319:0] x);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = 32'd0 - x[32*i +: 32];
    return r;
  endfunction

  assign b_s    = b;
  assign accept = (state == IDLE) && start;
  assign hit    = vld_p[LAST] && (babs == ({5'd0, idx_p[LAST]} + 8'd1));

  // Control: FSM, strobe generation, read-return valid pipeline, outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tbl_rd_en <= 1'b0;
      tbl_addr  <= 3'd0;
      drn       <= 2'd0;
      t_yplusx  <= '0;
      t_yminusx <= '0;
      t_xy2d    <= '0;
      for (int i = 0; i < TBL_RD_LAT; i++) vld_p[i] <= 1'b0;
`ifdef GE_SELECT_RANGE_CHK_EN
      b_err     <= 1'b0;
`endif
    end else begin
      vld_p[0] <= tbl_rd_en;
      for (int i = 1; i < TBL_RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tbl_rd_en <= 1'b1;
            tbl_addr  <= 3'd0;
            busy      <= 1'b1;
            state     <= READ;
`ifdef GE_SELECT_RANGE_CHK_EN
            b_err     <= (b_s > 8) || (b_s < -8);
`endif
          end
        end
        READ: begin
          // tbl_addr doubles as the read counter
          if (tbl_addr == 3'd7) begin
            tbl_rd_en <= 1'b0;
            drn       <= 2'd0;
            state     <= DRAIN;
          end else begin
            tbl_addr <= tbl_addr + 3'd1;
          end
        end
        DRAIN: begin
          if (drn == 2'(LAST)) state <= NEG;
          else                 drn   <= drn + 2'd1;
        end
        NEG: begin
          t_yplusx  <= mask_sel(acc_yminusx, acc_yplusx, bneg);
          t_yminusx <= mask_sel(acc_yplusx, acc_yminusx, bneg);
          t_xy2d    <= mask_sel(neg_limbs(acc_xy2d), acc_xy2d, bneg);
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          tbl_rd_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Data: digit decode, read-index pipeline, accumulator
  always_ff @(posedge clk) begin
    idx_p[0] <= tbl_addr;
    for (int i = 1; i < TBL_RD_LAT; i++) idx_p[i] <= idx_p[i-1];
    if (accept) begin
      bneg        <= b_s[7];
      babs        <= b_s[7] ? -b_s : b_s;
      acc_yplusx  <= FE_ONE;
      acc_yminusx <= FE_ONE;
      acc_xy2d    <= '0;
    end else begin
      acc_yplusx  <= mask_sel(tbl_yplusx,  acc_yplusx,  hit);
      acc_yminusx <= mask_sel(tbl_yminusx, acc_yminusx, hit);
      acc_xy2d    <= mask_sel(tbl_xy2d,    acc_xy2d,    hit);
    end
  end

endmodule

// File: tb/tb_ge_select_seq.sv
// Bench for ge_select_seq. Two instances run side by side with read latencies
// 1 and 2, each fed by its own delayed table model. A digit-level model
// predicts, for every cycle, the expected busy/done/strobe/address and t_*
// values. Directed runs add hand-computed literal expectations.
module tb_ge_select_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   b;
  logic         busy_w  [2];
  logic         done_w  [2];
  logic         rd_en_w [2];
  logic [2:0]   addr_w  [2];
  logic [319:0] tbl_yp  [2];
  logic [319:0] tbl_ym  [2];
  logic [319:0] tbl_xy  [2];
  logic [319:0] typ_w   [2];
  logic [319:0] tym_w   [2];
  logic [319:0] txy_w   [2];
`ifdef GE_SELECT_RANGE_CHK_EN
  logic         b_err_w [2];
`endif

  int errs   = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Model state per instance
  bit           act  [2];
  int           cyc  [2];
  logic [7:0]   lb   [2];
  logic [319:0] eyp  [2];
  logic [319:0] eym  [2];
  logic [319:0] exy  [2];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [319:0] a, input logic [319:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Entry k: limb0 = 0x100*(k+1) in every field. The other limbs are k,
  // plus 0x1000 in yminusx so that a swap is visible.
  function automatic logic [319:0] entry(input int k, input int f);
    logic [319:0] r;
    r[31:0] = 32'(256 * (k + 1));
    for (int i = 1; i < 10; i++) r[32*i +: 32] = 32'(k + ((f == 1) ? 32'h1000 : 0));
    return r;
  endfunction

  // Expected point for a digit, computed from integer arithmetic on b
  function automatic void model_sel(input logic [7:0] bv, output logic [319:0] yp,
                                    output logic [319:0] ym, output logic [319:0] xy);
    int v, m;
    logic [319:0] a, q, x;
    v = int'($signed(bv));
    m = (v < 0) ? -v : v;
    if (m >= 1 && m <= 8) begin
      a = entry(m - 1, 0); q = entry(m - 1, 1); x = entry(m - 1, 2);
    end else begin
      a = 320'd1; q = 320'd1; x = '0;
    end
    xy = '0;
    if (v < 0) begin
      yp = q; ym = a;
      for (int i = 0; i < 10; i++) xy[32*i +: 32] = 32'd0 - x[32*i +: 32];
    end else begin
      yp = a; ym = q; xy = x;
    end
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int L = d + 1;
    logic       pv [2];
    logic [2:0] pa [2];
    logic       vs;
    logic [2:0] as;

    ge_select_seq #(.TBL_RD_LAT(L)) u (
      .clk(clk), .rst(rst), .start(start), .b(b),
      .busy(busy_w[d]), .done(done_w[d]),
      .tbl_rd_en(rd_en_w[d]), .tbl_addr(addr_w[d]),
      .tbl_yplusx(tbl_yp[d]), .tbl_yminusx(tbl_ym[d]), .tbl_xy2d(tbl_xy[d]),
      .t_yplusx(typ_w[d]), .t_yminusx(tym_w[d]), .t_xy2d(txy_w[d])
`ifdef GE_SELECT_RANGE_CHK_EN
      , .b_err(b_err_w[d])
`endif
    );

    // Table: data for a strobe appears L cycles later; garbage otherwise
    always @(posedge clk) begin
      pv[0] <= rd_en_w[d]; pa[0] <= addr_w[d];
      pv[1] <= pv[0];      pa[1] <= pa[0];
    end
    assign vs = (L == 1) ? pv[0] : pv[1];
    assign as = (L == 1) ? pa[0] : pa[1];
    assign tbl_yp[d] = vs ? entry(int'(as), 0) : {10{32'hA5A5A5A5}};
    assign tbl_ym[d] = vs ? entry(int'(as), 1) : {10{32'h5A5A5A5A}};
    assign tbl_xy[d] = vs ? entry(int'(as), 2) : {10{32'hC3C3C3C3}};

    // Model: a call occupies 10+L cycles after accept, and t_* update on
    // its last-but-one edge
    always @(posedge clk) begin
      logic [319:0] y1, y2, y3;
      if (rst) begin
        act[d] = 1'b0; cyc[d] = 0; eyp[d] = '0; eym[d] = '0; exy[d] = '0;
      end else if (act[d]) begin
        cyc[d]++;
        if (cyc[d] == 9 + L) begin
          model_sel(lb[d], y1, y2, y3);
          eyp[d] = y1; eym[d] = y2; exy[d] = y3;
        end
        if (cyc[d] == 10 + L) act[d] = 1'b0;
      end else if (start) begin
        act[d] = 1'b1; cyc[d] = 0; lb[d] = b;
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        bit erd;
        erd = act[d] && (cyc[d] <= 7);
        chk_i($sformatf("u%0d busy", d), int'(busy_w[d]), int'(act[d]));
        chk_i($sformatf("u%0d done", d), int'(done_w[d]), int'(act[d] && cyc[d] == 9 + L));
        chk_i($sformatf("u%0d rd_en", d), int'(rd_en_w[d]), int'(erd));
        if (erd) chk_i($sformatf("u%0d addr", d), int'(addr_w[d]), cyc[d]);
        chk($sformatf("u%0d t_yplusx", d), typ_w[d], eyp[d]);
        chk($sformatf("u%0d t_yminusx", d), tym_w[d], eym[d]);
        chk($sformatf("u%0d t_xy2d", d), txy_w[d], exy[d]);
      end
    end
  end

  // mode 0: plain call; 1: start re-pulsed during READ; 2: rst at 4th READ cycle
  task automatic run(input logic [7:0] bv, input int mode,
                     output int lat0, output int lat1, output int strobes);
    @(negedge clk);
    b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat0 = -1; lat1 = -1; strobes = 0;
    for (int n = 0; n < 40; n++) begin
      if (rd_en_w[0]) strobes++;
      if (done_w[0] && lat0 < 0) lat0 = n;
      if (done_w[1] && lat1 < 0) lat1 = n;
      if (mode == 1 && n == 3) begin start = 1'b1; b = 8'd7; end
      if (mode == 1 && n == 4) start = 1'b0;
      if (mode == 2 && n == 3) rst = 1'b1;
      if (mode == 2 && n == 4) begin rst = 1'b0; break; end
      if (lat0 >= 0 && lat1 >= 0 && !busy_w[0] && !busy_w[1]) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int l0, l1, s;
    rst = 1'b1; start = 1'b0; b = 8'd0;
    @(posedge clk);
    armed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_i("reset busy", int'(busy_w[0]), 0);
    chk_i("reset addr", int'(addr_w[0]), 0);
    chk("reset t_yplusx", typ_w[0], '0);
    rst = 1'b0;

    run(8'd3, 0, l0, l1, s);
    chk_i("b=+3 latency L1", l0, 10);
    chk_i("b=+3 latency L2", l1, 11);
    chk_i("b=+3 strobes", s, 8);
    chk("b=+3 yplusx limb0", {288'd0, typ_w[0][31:0]}, 320'h300);
    chk("b=+3 xy2d limb0", {288'd0, txy_w[0][31:0]}, 320'h300);

    run(8'hFB, 0, l0, l1, s);
    chk("b=-5 yplusx limb0", {288'd0, typ_w[0][31:0]}, 320'h500);
    chk("b=-5 yplusx limb1", {288'd0, typ_w[0][63:32]}, 320'h1004);
    chk("b=-5 yminusx limb1", {288'd0, tym_w[0][63:32]}, 320'h4);
    chk("b=-5 xy2d limb0", {288'd0, txy_w[0][31:0]}, 320'hFFFFFB00);
    chk("b=-5 xy2d limb9", {288'd0, txy_w[0][319:288]}, 320'hFFFFFFFC);

    run(8'd0, 0, l0, l1, s);
    chk_i("b=0 latency", l0, 10);
    chk("b=0 yplusx", typ_w[0], 320'd1);
    chk("b=0 yminusx", tym_w[0], 320'd1);
    chk("b=0 xy2d", txy_w[0], '0);
`ifdef GE_SELECT_RANGE_CHK_EN
    chk_i("b=0 b_err", int'(b_err_w[0]), 0);
`endif

    run(8'h80, 0, l0, l1, s);
    chk_i("b=-128 latency", l0, 10);
    chk("b=-128 yplusx", typ_w[0], 320'd1);
    chk("b=-128 yminusx", tym_w[0], 320'd1);
    chk("b=-128 xy2d", txy_w[0], '0);
`ifdef GE_SELECT_RANGE_CHK_EN
    chk_i("b=-128 b_err", int'(b_err_w[0]), 1);
`endif

    run(8'd8, 0, l0, l1, s);
    chk_i("b=+8 latency L2", l1, 11);
    chk("b=+8 L2 yplusx limb0", {288'd0, typ_w[1][31:0]}, 320'h800);
    chk("b=+8 L2 yminusx limb1", {288'd0, tym_w[1][63:32]}, 320'h1007);

    run(8'hF8, 0, l0, l1, s);
    chk("b=-8 yplusx limb1", {288'd0, typ_w[0][63:32]}, 320'h1007);
    chk("b=-8 xy2d limb0", {288'd0, txy_w[0][31:0]}, 320'hFFFFF800);

    run(8'd9, 0, l0, l1, s);
    chk("b=+9 yplusx", typ_w[0], 320'd1);
    chk("b=+9 xy2d", txy_w[0], '0);
`ifdef GE_SELECT_RANGE_CHK_EN
    chk_i("b=+9 b_err", int'(b_err_w[0]), 1);
`endif

    run(8'd2, 1, l0, l1, s);
    chk_i("repulse latency", l0, 10);
    chk_i("repulse strobes", s, 8);
    chk("repulse yplusx limb0", {288'd0, typ_w[0][31:0]}, 320'h200);

    run(8'd6, 2, l0, l1, s);
    chk_i("abort busy", int'(busy_w[0]), 0);
    chk_i("abort rd_en", int'(rd_en_w[0]), 0);
    chk_i("abort done seen", l0, -1);
    chk("abort t_yplusx", typ_w[0], '0);

    run(8'd1, 0, l0, l1, s);
    chk_i("b=+1 latency", l0, 10);
    chk("b=+1 yplusx limb0", {288'd0, typ_w[0][31:0]}, 320'h100);
    chk("b=+1 yminusx limb1", {288'd0, tym_w[0][63:32]}, 320'h1000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ge_select_seq.md
Name: ge_select_seq

Overview:
- Sequential constant-time table selector for the Ed25519 fixed-base scalar multiply. It is the producer side of the conditional-move datapath.
- Given a signed radix-16 digit b in [-8,8], it reads all 8 ge_precomp entries of one table row through a read port. Entries are held in multiples 1..8.
- Entries are conditionally moved into an accumulator that starts at identity, then conditionally negated. This is ref10 ge_select.
- The access pattern and latency are independent of b.

Parameters:
- TBL_RD_LAT, 1: table read latency in cycles from tbl_rd_en to valid tbl_* data. Legal values are 1 and 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- b  in  8  signed digit; latched when start is accepted
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; t_* are valid from this cycle on
- tbl_rd_en  out  1  table read strobe
- tbl_addr  out  3  entry index k, which holds multiple k+1
- tbl_yplusx  in  320  entry yplusx: 10 x 32-bit signed limbs, limb0 at [31:0]
- tbl_yminusx  in  320  entry yminusx
- tbl_xy2d  in  320  entry xy2d
- t_yplusx  out  320  selected yplusx, registered
- t_yminusx  out  320  selected yminusx, registered
- t_xy2d  out  320  selected xy2d, registered

Behaviour:
- Reset:
  - state=IDLE.
  - busy, done, tbl_rd_en = 0; tbl_addr = 0.
  - t_yplusx, t_yminusx, t_xy2d = 0.
  - Reset mid-operation aborts immediately; no done is produced.
- Digit decode, on the start-accept edge:
  - bneg = b[7].
  - babs = bneg ? -b : b, computed in 8 bits with wrap.
  - Latch bneg and babs.
- States are IDLE -> READ -> DRAIN -> NEG -> DONE -> IDLE.
- IDLE:
  - On start=1, latch the digit.
  - Load the accumulator with identity: yplusx = yminusx = fe_1 (limb0 = 1, other limbs 0), xy2d = 0.
  - Clear cnt and go to READ.
  - With start=0, stay in IDLE; outputs hold their last values.
- READ, 8 cycles:
  - tbl_rd_en=1 and tbl_addr=cnt, cnt = 0..7; then go to DRAIN.
- Accumulate:
  - Data for address k arrives TBL_RD_LAT cycles after its strobe.
  - On that edge, replace all three accumulator fields with the tbl_* values if babs == k+1; otherwise hold.
  - Use mask-select (all-ones or all-zeros mask per bit), not a data-dependent enable.
  - Every entry is read exactly once, in order 0..7, regardless of b.
- DRAIN: TBL_RD_LAT cycles with tbl_rd_en=0; absorbs the remaining read data.
- NEG, 1 cycle, applied with a bneg mask:
  - t_yplusx <- acc_yminusx.
  - t_yminusx <- acc_yplusx.
  - t_xy2d <- per-limb 32-bit two's-complement negation of acc_xy2d, modulo 2^32, with no carry between limbs.
  - If bneg=0, t_* <- acc unchanged.
- DONE: done=1 for one cycle, then IDLE. busy is high in READ, DRAIN, NEG and DONE.
- Latency: start sampled at edge N gives done high in cycle N+10+TBL_RD_LAT, which is fixed for every b.
- start while busy is ignored; it is not queued.
- start in the same cycle as done is ignored, because the FSM is still in DONE.
- Out-of-range digits (b in 9..127 or -128..-9) match no entry:
  - The result is identity, with the NEG swap applied if bneg.
  - Identity negated equals identity: 1, 1, 0.
- t_* only change in the NEG cycle and hold until the next NEG.

Optional Feature:
- Macro: GE_SELECT_RANGE_CHK_EN.
- When defined:
  - Adds output b_err (1 bit, reset 0).
  - b_err is set at start-accept if the latched b lies outside [-8,8], and is cleared at the next accept.
  - It is valid from done onward.
  - Selection and timing are unchanged.
- When undefined: no b_err port and no extra logic.

Test Plan:
- b=+3, TBL_RD_LAT=1, table entry k with limb0 = 0x100*(k+1) in all fields and other limbs equal to k:
  - done at cycle N+11.
  - t_yplusx limb0 = 0x300; t_xy2d limb0 = 0x300.
  - Exactly 8 strobes with addr 0..7.
- b=-5 (0xFB), same table:
  - t_yplusx = entry4.yminusx and t_yminusx = entry4.yplusx.
  - t_xy2d limb0 = 0xFFFFFB00 (= -0x500); limbs 1..9 = 0xFFFFFFFC.
- b=0, then b=-0x80:
  - Both give t_yplusx = t_yminusx = 1 (limb0) and t_xy2d = 0.
  - Latency is identical to the b=+3 run.
  - With GE_SELECT_RANGE_CHK_EN: b_err=0 for b=0 and b_err=1 for b=-0x80.
- b=+8 with TBL_RD_LAT=2 (table model delays data 2 cycles): selects entry 7; done at N+12.
- start re-pulsed during READ: ignored, single done.
- Apply rst at the 4th READ cycle: busy, tbl_rd_en and done drop next cycle; t_* = 0; a fresh start with b=+1 selects entry 0 correctly.
